// File: rtl/grid_pkg.sv
// Shared types and constants for the grid locator: the "no cell" code and the FSM states.
package grid_pkg;

  localparam int LOC_W_MAX = 16;
  localparam logic [LOC_W_MAX-1:0] LOC_NONE = '1;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

endpackage

// File: rtl/grid_locator_if.sv
// Pixel stream, runtime configuration and location report of the grid locator.
interface grid_locator_if #(
  parameter int DATA_W  = 12,
  parameter int COORD_W = 16,
  parameter int CNT_W   = 20,
  parameter int LOC_W   = 4
);
  logic [DATA_W-1:0]  iDATA;
  logic               iDVAL;
  logic [COORD_W-1:0] iX_Cont;
  logic [COORD_W-1:0] iY_Cont;
  logic [31:0]        iFrame;
  logic [DATA_W-1:0]  iThreshold;
  logic               iDark;
  logic [CNT_W-1:0]   iMinCount;
  logic [LOC_W-1:0]   oLoc;
  logic               oValid;
  logic               oInterrupt;
  logic               oBusy;
  logic               oDrop;

  modport master (
    output iDATA, iDVAL, iX_Cont, iY_Cont, iFrame, iThreshold, iDark, iMinCount,
    input  oLoc, oValid, oInterrupt, oBusy, oDrop
  );

  modport slave (
    input  iDATA, iDVAL, iX_Cont, iY_Cont, iFrame, iThreshold, iDark, iMinCount,
    output oLoc, oValid, oInterrupt, oBusy, oDrop
  );
endinterface

// File: rtl/grid_cell_index.sv
// Maps a pixel coordinate to its row-major grid cell using constant boundary compares.
module grid_cell_index #(
  parameter int COORD_W   = 16,
  parameter int FRAME_W   = 640,
  parameter int FRAME_H   = 480,
  parameter int GRID_COLS = 3,
  parameter int GRID_ROWS = 3,
  parameter int LOC_W     = 4
) (
  input  logic [COORD_W-1:0] x_coord,
  input  logic [COORD_W-1:0] y_coord,
  output logic [LOC_W-1:0]   cell_idx,
  output logic               in_range
);
  localparam int CELL_W = FRAME_W / GRID_COLS;
  localparam int CELL_H = FRAME_H / GRID_ROWS;
  localparam int X_LIM  = GRID_COLS * CELL_W;
  localparam int Y_LIM  = GRID_ROWS * CELL_H;

  logic [LOC_W-1:0] col_s;
  logic [LOC_W-1:0] row_s;

  // Column/row = number of cell boundaries at or left/above the coordinate
  always_comb begin
    col_s = '0;
    row_s = '0;
    for (int k = 1; k < GRID_COLS; k++) begin
      if (x_coord >= COORD_W'(k * CELL_W)) col_s = col_s + 1'b1;
      else                                  col_s = col_s;
    end
    for (int k = 1; k < GRID_ROWS; k++) begin
      if (y_coord >= COORD_W'(k * CELL_H)) row_s = row_s + 1'b1;
      else                                  row_s = row_s;
    end
    in_range = (x_coord < COORD_W'(X_LIM)) && (y_coord < COORD_W'(Y_LIM));
    cell_idx = LOC_W'(int'(row_s) * GRID_COLS + int'(col_s));
  end
endmodule

// File: rtl/grid_locator.sv
// Per-cell hit counting over a configurable grid; reports the strongest cell once it
// has won STABLE_FRAMES consecutive frames.
module grid_locator
  import grid_pkg::*;
#(
  parameter int DATA_W        = 12,
  parameter int COORD_W       = 16,
  parameter int FRAME_W       = 640,
  parameter int FRAME_H       = 480,
  parameter int GRID_COLS     = 3,
  parameter int GRID_ROWS     = 3,
  parameter int CNT_W         = 20,
  parameter int STABLE_FRAMES = 3,
  parameter int LOC_W         = 4
) (
  input  logic          iCLK,
  input  logic          iRST,
  grid_locator_if.slave bus
);
  localparam int N     = GRID_COLS * GRID_ROWS;
  localparam int STB_W = $clog2(STABLE_FRAMES + 1);
  localparam logic [LOC_W-1:0] NONE_C   = LOC_NONE[LOC_W-1:0];
  localparam logic [LOC_W-1:0] LAST_IDX = LOC_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_FRAMES);

  state_t           state_r;
  logic [CNT_W-1:0] acc_r [N];
  logic [31:0]      frame_r;
  logic [LOC_W-1:0] scan_idx_r, arg_r, prev_cand_r, loc_r;
  logic [CNT_W-1:0] max_r;
  logic [STB_W-1:0] stable_r;
  logic             valid_r, irq_r, busy_r, drop_r;

  logic [DATA_W-1:0] data_s;
  logic [LOC_W-1:0]  cell_s, cand_s;
  logic [STB_W-1:0]  stable_nxt_s;
  logic              in_range_s, hit_s, frame_edge_s;

  grid_cell_index #(
    .COORD_W(COORD_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H),
    .GRID_COLS(GRID_COLS), .GRID_ROWS(GRID_ROWS), .LOC_W(LOC_W)
  ) u_cell_index (
    .x_coord (bus.iX_Cont),
    .y_coord (bus.iY_Cont),
    .cell_idx(cell_s),
    .in_range(in_range_s)
  );

  // Hit qualification, frame edge and the per-frame candidate decision
  always_comb begin
    data_s       = bus.iDATA;
    hit_s        = bus.iDVAL && in_range_s &&
                   (bus.iDark ? (data_s < bus.iThreshold) : (data_s >= bus.iThreshold));
    frame_edge_s = (bus.iFrame != frame_r);
    cand_s       = (max_r >= bus.iMinCount) ? arg_r : NONE_C;
    if (cand_s == prev_cand_r) begin
      stable_nxt_s = (stable_r >= STB_MAX) ? STB_MAX : stable_r + 1'b1;
    end else begin
      stable_nxt_s = STB_W'(1);
    end
  end

  // Saturating accumulators, cleared together in CLEAR
  always_ff @(posedge iCLK) begin
    if (iRST || state_r == ST_CLEAR) begin
      for (int i = 0; i < N; i++) acc_r[i] <= '0;
    end else if (state_r == ST_ACCUM && hit_s) begin
      if (acc_r[cell_s] != CNT_MAX) acc_r[cell_s] <= acc_r[cell_s] + 1'b1;
    end
  end

  // Control FSM with registered report outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r     <= ST_ACCUM;
      frame_r     <= bus.iFrame;
      scan_idx_r  <= '0;
      arg_r       <= '0;
      max_r       <= '0;
      prev_cand_r <= NONE_C;
      stable_r    <= '0;
      loc_r       <= NONE_C;
      valid_r     <= 1'b0;
      irq_r       <= 1'b0;
      busy_r      <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      // Tracking iFrame while busy swallows edges seen then
      frame_r <= bus.iFrame;
      irq_r   <= 1'b0;
      if (bus.iDVAL && state_r != ST_ACCUM) drop_r <= 1'b1;
      case (state_r)
        ST_ACCUM: begin
          if (frame_edge_s) begin
            state_r    <= ST_SCAN;
            scan_idx_r <= '0;
            busy_r     <= 1'b1;
          end
        end
        ST_SCAN: begin
          // Strict compare keeps the lower index on ties
          if (scan_idx_r == '0 || acc_r[scan_idx_r] > max_r) begin
            max_r <= acc_r[scan_idx_r];
            arg_r <= scan_idx_r;
          end
          if (scan_idx_r == LAST_IDX) state_r <= ST_DECIDE;
          else                        scan_idx_r <= scan_idx_r + 1'b1;
        end
        ST_DECIDE: begin
          prev_cand_r <= cand_s;
          stable_r    <= stable_nxt_s;
          if (stable_nxt_s == STB_MAX) begin
            loc_r   <= cand_s;
            valid_r <= (cand_s != NONE_C);
            irq_r   <= (cand_s != NONE_C) && (cand_s != loc_r);
          end
          state_r <= ST_CLEAR;
        end
        ST_CLEAR: begin
          state_r <= ST_ACCUM;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_ACCUM;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oLoc       = loc_r;
  assign bus.oValid     = valid_r;
  assign bus.oInterrupt = irq_r;
  assign bus.oBusy      = busy_r;
  assign bus.oDrop      = drop_r;
endmodule

// File: tb/tb_grid_locator.sv
// Randomised + directed bench: a frame-level reference model queues expected reports,
// a monitor checks them whenever the DUT finishes a decision.
module tb_grid_locator;
  localparam int DATA_W = 12, COORD_W = 16, FRAME_W = 12, FRAME_H = 9;
  localparam int GRID_COLS = 4, GRID_ROWS = 3, CNT_W = 4, STABLE_FRAMES = 2, LOC_W = 4;
  localparam int N = GRID_COLS * GRID_ROWS;
  localparam int NONE = 15;
  localparam int SAT = 15;

  typedef struct {
    int loc;
    int valid;
    int irq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grid_locator_if #(.DATA_W(DATA_W), .COORD_W(COORD_W), .CNT_W(CNT_W), .LOC_W(LOC_W)) bus ();

  grid_locator #(
    .DATA_W(DATA_W), .COORD_W(COORD_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H),
    .GRID_COLS(GRID_COLS), .GRID_ROWS(GRID_ROWS), .CNT_W(CNT_W),
    .STABLE_FRAMES(STABLE_FRAMES), .LOC_W(LOC_W)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   stray_irq = 0;
  exp_t exp_q[$];

  int m_cnt[N];
  int m_prev, m_run, m_loc, m_valid;
  int thr = 100, dark = 0, minc = 4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_prev = NONE; m_run = 0; m_loc = NONE; m_valid = 0;
  endtask

  task automatic apply_cfg();
    bus.iThreshold = DATA_W'(thr);
    bus.iDark      = dark[0];
    bus.iMinCount  = CNT_W'(minc);
  endtask

  // Drive one pixel for the next edge and account for it in the model
  task automatic pixel(input int x, input int y, input int d, input bit dv);
    bus.iX_Cont = COORD_W'(x);
    bus.iY_Cont = COORD_W'(y);
    bus.iDATA   = DATA_W'(d);
    bus.iDVAL   = dv;
    if (dv && x < FRAME_W && y < FRAME_H) begin
      if ((dark != 0) ? (d < thr) : (d >= thr)) begin
        int c;
        c = (y / (FRAME_H / GRID_ROWS)) * GRID_COLS + x / (FRAME_W / GRID_COLS);
        if (m_cnt[c] < SAT) m_cnt[c]++;
      end
    end
  endtask

  task automatic fill_cell(input int c, input int v, input int n);
    for (int k = 0; k < n; k++) begin
      pixel((c % GRID_COLS) * 3 + k % 3, (c / GRID_COLS) * 3 + (k / 3) % 3, v, 1'b1);
      tick();
    end
    bus.iDVAL = 1'b0;
  endtask

  // Close the frame: optional pixel on the edge cycle, optional disturbance while busy
  task automatic frame_end(input bit wp, input int x, input int y, input int d, input bit disturb);
    int   best, cand;
    exp_t e;
    if (wp) pixel(x, y, d, 1'b1);
    else    bus.iDVAL = 1'b0;
    best = 0;
    for (int i = 1; i < N; i++) if (m_cnt[i] > m_cnt[best]) best = i;
    cand = (m_cnt[best] >= minc) ? best : NONE;
    m_run  = (cand == m_prev) ? m_run + 1 : 1;
    m_prev = cand;
    e.irq  = 0;
    if (m_run >= STABLE_FRAMES) begin
      e.irq   = (cand != NONE && cand != m_loc) ? 1 : 0;
      m_loc   = cand;
      m_valid = (cand != NONE) ? 1 : 0;
    end
    e.loc = m_loc; e.valid = m_valid;
    exp_q.push_back(e);
    foreach (m_cnt[i]) m_cnt[i] = 0;
    bus.iFrame = bus.iFrame + 32'd1;
    tick();
    bus.iDVAL = 1'b0;
    if (disturb) begin
      tick(); tick();
      bus.iX_Cont = '0; bus.iY_Cont = '0; bus.iDATA = 12'd4000; bus.iDVAL = 1'b1;
      tick();
      bus.iDVAL  = 1'b0;
      bus.iFrame = bus.iFrame + 32'd1;
      tick();
    end
    repeat (N + 4) tick();
    check("busy_after_frame", {31'd0, bus.oBusy}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_loc"},   {28'd0, bus.oLoc}, 32'd15);
    check({tag, "_valid"}, {31'd0, bus.oValid}, 32'd0);
    check({tag, "_irq"},   {31'd0, bus.oInterrupt}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.oBusy}, 32'd0);
    check({tag, "_drop"},  {31'd0, bus.oDrop}, 32'd0);
  endtask

  // Monitor: a falling oBusy marks a completed decision
  initial begin
    bit   bp;
    int   cyc, nirq, irqpos;
    exp_t e;
    bp = 1'b0; cyc = 0; nirq = 0; irqpos = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bp = 1'b0; cyc = 0; nirq = 0;
      end else begin
        if (bus.oBusy && !bp) cyc = 1;
        else if (bus.oBusy)   cyc++;
        if (bus.oInterrupt === 1'b1) begin
          if (bus.oBusy) begin nirq++; irqpos = cyc; end
          else stray_irq++;
        end
        if (!bus.oBusy && bp) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_report", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("sb_loc",   {28'd0, bus.oLoc}, e.loc);
            check("sb_valid", {31'd0, bus.oValid}, e.valid);
            check("sb_irq_count", nirq, e.irq);
            if (e.irq != 0) check("sb_irq_cycle", irqpos, N + 2);
          end
          nirq = 0;
        end
        bp = bus.oBusy;
      end
    end
  end

  initial begin
    int fav;
    bus.iDATA = '0; bus.iDVAL = 1'b0; bus.iX_Cont = '0; bus.iY_Cont = '0;
    bus.iFrame = 32'd0;
    apply_cfg();
    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // Idle frames: reported "none" without a pulse
    frame_end(1'b0, 0, 0, 0, 1'b0);
    frame_end(1'b0, 0, 0, 0, 1'b0);

    // Cell 6 for three frames
    repeat (3) begin
      fill_cell(6, 200, 9);
      frame_end(1'b0, 0, 0, 0, 1'b0);
    end

    // Tie between cells 3 and 8
    repeat (2) begin
      fill_cell(8, 200, 5);
      fill_cell(3, 200, 5);
      frame_end(1'b0, 0, 0, 0, 1'b0);
    end

    // Below minimum count
    repeat (2) begin
      fill_cell(9, 200, 3);
      frame_end(1'b0, 0, 0, 0, 1'b0);
    end

    // Dark polarity over a full raster
    dark = 1; apply_cfg();
    repeat (2) begin
      for (int y = 0; y < FRAME_H; y++) begin
        for (int x = 0; x < FRAME_W; x++) begin
          pixel(x, y, (x >= 9 && y >= 6) ? 10 : 200, 1'b1);
          tick();
        end
      end
      frame_end(1'b0, 0, 0, 0, 1'b0);
    end
    dark = 0; apply_cfg();

    // Saturation: both cells pinned at max, lower index wins
    repeat (2) begin
      fill_cell(2, 300, 20);
      fill_cell(1, 300, 20);
      frame_end(1'b0, 0, 0, 0, 1'b0);
    end

    // Fourth hit arrives on the frame-edge cycle and must still count
    repeat (2) begin
      fill_cell(5, 150, 3);
      frame_end(1'b1, 4, 4, 150, 1'b0);
    end

    // Pixel and frame edge while busy
    check("drop_before", {31'd0, bus.oDrop}, 32'd0);
    fill_cell(7, 200, 6);
    frame_end(1'b0, 0, 0, 0, 1'b1);
    check("drop_sticky", {31'd0, bus.oDrop}, 32'd1);

    // Reset in the middle of a scan
    fill_cell(4, 200, 9);
    bus.iFrame = bus.iFrame + 32'd1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick();
    check_reset_state("midscan_reset");
    rst = 1'b0;
    model_reset();
    tick();
    repeat (2) begin
      fill_cell(6, 200, 9);
      frame_end(1'b0, 0, 0, 0, 1'b0);
    end

    // Randomised frames biased toward a slowly changing favourite cell
    fav = 0;
    for (int f = 0; f < 40; f++) begin
      int n;
      if ($urandom_range(0, 3) == 0) fav = $urandom_range(0, N - 1);
      if ($urandom_range(0, 4) == 0) begin
        thr  = $urandom_range(0, 4095);
        dark = $urandom_range(0, 1);
        minc = $urandom_range(0, 8);
        apply_cfg();
      end
      n = $urandom_range(0, 40);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 0)
          pixel((fav % GRID_COLS) * 3 + $urandom_range(0, 2), (fav / GRID_COLS) * 3 + $urandom_range(0, 2),
                $urandom_range(0, 4095), $urandom_range(0, 3) != 0);
        else
          pixel($urandom_range(0, 14), $urandom_range(0, 10), $urandom_range(0, 4095), $urandom_range(0, 3) != 0);
        tick();
      end
      if ($urandom_range(0, 1) == 0)
        frame_end(1'b1, $urandom_range(0, 14), $urandom_range(0, 10), $urandom_range(0, 4095), 1'b0);
      else
        frame_end(1'b0, 0, 0, 0, 1'b0);
    end

    repeat (20) tick();
    check("sb_pending", exp_q.size(), 32'd0);
    check("stray_irq", stray_irq, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
